// File: rtl/vce2_vec_seq.sv
// Vector operation sequencer: walks AGU setup, operand reads,
// execute and write-back for vl 32-bit elements.
module vce2_vec_seq #(
  parameter int unsigned VlWidth = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [VlWidth-1:0] vl_i,
  input  logic               two_src_i,
  output logic               agu_load_o,
  input  logic               agu_ready_i,
  output logic               get_rs1_o,
  output logic               get_rs2_o,
  output logic               get_rd_o,
  output logic               incr_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  output logic               opa_we_o,
  output logic               opb_we_o,
  output logic               exec_o,
  input  logic               res_valid_i,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [3:0] {
    IDLE,
    AGU_LD,
    AGU_WAIT,
    RA_REQ,
    RA_WAIT,
    RB_REQ,
    RB_WAIT,
    EXEC_ST,
    EXEC_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [VlWidth-1:0] cnt_q, cnt_d;
  logic               src2_q, src2_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src2_q  <= src2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src2_d     = src2_q;
    agu_load_o = 1'b0;
    get_rs1_o  = 1'b0;
    get_rs2_o  = 1'b0;
    get_rd_o   = 1'b0;
    incr_o     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    opa_we_o   = 1'b0;
    opb_we_o   = 1'b0;
    exec_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = vl_i;
          src2_d  = two_src_i;
          state_d = (vl_i == '0) ? DONE : AGU_LD;
        end
      end
      AGU_LD: begin
        agu_load_o = 1'b1;
        state_d    = AGU_WAIT;
      end
      AGU_WAIT: begin
        if (agu_ready_i) state_d = RA_REQ;
      end
      RA_REQ: begin
        mem_req_o = 1'b1;
        get_rs1_o = 1'b1;
        incr_o    = mem_gnt_i;
        if (mem_gnt_i) state_d = RA_WAIT;
      end
      RA_WAIT: begin
        opa_we_o = mem_rvalid_i;
        if (mem_rvalid_i) state_d = src2_q ? RB_REQ : EXEC_ST;
      end
      RB_REQ: begin
        mem_req_o = 1'b1;
        get_rs2_o = 1'b1;
        incr_o    = mem_gnt_i;
        if (mem_gnt_i) state_d = RB_WAIT;
      end
      RB_WAIT: begin
        opb_we_o = mem_rvalid_i;
        if (mem_rvalid_i) state_d = EXEC_ST;
      end
      EXEC_ST: begin
        exec_o  = 1'b1;
        state_d = EXEC_WAIT;
      end
      EXEC_WAIT: begin
        if (res_valid_i) state_d = WR_REQ;
      end
      WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        get_rd_o  = 1'b1;
        incr_o    = mem_gnt_i;
        if (mem_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_rvalid_i) begin
          cnt_d   = cnt_q - VlWidth'(1);
          state_d = (cnt_q == VlWidth'(1)) ? DONE : RA_REQ;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_vce2_vec_seq.sv
// Bench for vce2_vec_seq: step-list reference model plus
// directed scenarios with literal count checks.
module tb_vce2_vec_seq;

  logic       clk_i;
  logic       rst_ni;
  logic       start_i;
  logic       start_drv;
  logic       start_inj;
  logic [7:0] vl_i;
  logic       two_src_i;
  logic       agu_load_o;
  logic       agu_ready_i;
  logic       get_rs1_o;
  logic       get_rs2_o;
  logic       get_rd_o;
  logic       incr_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       mem_gnt_i;
  logic       mem_rvalid_i;
  logic       opa_we_o;
  logic       opb_we_o;
  logic       exec_o;
  logic       res_valid_i;
  logic       busy_o;
  logic       done_o;

  assign start_i = start_drv | start_inj;

  vce2_vec_seq #(.VlWidth(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .vl_i        (vl_i),
    .two_src_i   (two_src_i),
    .agu_load_o  (agu_load_o),
    .agu_ready_i (agu_ready_i),
    .get_rs1_o   (get_rs1_o),
    .get_rs2_o   (get_rs2_o),
    .get_rd_o    (get_rd_o),
    .incr_o      (incr_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .opa_we_o    (opa_we_o),
    .opb_we_o    (opb_we_o),
    .exec_o      (exec_o),
    .res_valid_i (res_valid_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam int B_AGU  = 0;
  localparam int B_INC  = 1;
  localparam int B_RD   = 2;
  localparam int B_RS2  = 3;
  localparam int B_RS1  = 4;
  localparam int B_WE   = 5;
  localparam int B_REQ  = 6;
  localparam int B_OPB  = 7;
  localparam int B_OPA  = 8;
  localparam int B_EXE  = 9;
  localparam int B_DONE = 10;
  localparam int B_BUSY = 11;

  // Operation steps: each advances on its own handshake
  localparam int K_LOAD  = 0;
  localparam int K_AWAIT = 1;
  localparam int K_REQA  = 2;
  localparam int K_RSPA  = 3;
  localparam int K_REQB  = 4;
  localparam int K_RSPB  = 5;
  localparam int K_EXEC  = 6;
  localparam int K_XWAIT = 7;
  localparam int K_WREQ  = 8;
  localparam int K_WRSP  = 9;
  localparam int K_DONE  = 10;

  int gnt_delay_cfg;
  int res_delay;
  bit inject;

  initial begin
    int  gw;
    int  aw;
    int  rw;
    bit  pend;
    bit  in_aw;
    bit  xw;
    bit  req_prev;
    bit  agu_seen;
    bit  exec_seen;
    agu_ready_i  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    res_valid_i  = 1'b0;
    start_inj    = 1'b0;
    gw = 0; aw = 0; rw = 0;
    pend = 0; in_aw = 0; xw = 0;
    req_prev = 0; agu_seen = 0; exec_seen = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        agu_ready_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        res_valid_i  = 1'b0;
        start_inj    = 1'b0;
        gw = 0; aw = 0; rw = 0;
        pend = 0; in_aw = 0; xw = 0;
        req_prev = 0; agu_seen = 0; exec_seen = 0;
      end else begin
        mem_rvalid_i = pend;
        start_inj    = 1'b0;
        res_valid_i  = 1'b0;
        agu_ready_i  = 1'b0;
        if (agu_seen) begin
          in_aw = 1; aw = 2;
        end
        if (in_aw) begin
          if (aw > 0) aw--;
          else begin
            agu_ready_i = 1'b1; in_aw = 0;
          end
        end
        if (exec_seen) begin
          xw = 1; rw = res_delay;
        end
        if (xw) begin
          if (rw > 0) begin
            rw--;
            if (inject) begin
              mem_rvalid_i = 1'b1;
              start_inj    = 1'b1;
            end
          end else begin
            res_valid_i = 1'b1; xw = 0;
          end
        end
        if (mem_req_o && !req_prev) gw = gnt_delay_cfg;
        mem_gnt_i = mem_req_o && (gw == 0);
        if (mem_req_o && gw > 0) gw--;
        pend      = mem_req_o && mem_gnt_i;
        req_prev  = mem_req_o;
        agu_seen  = agu_load_o;
        exec_seen = exec_o;
      end
    end
  end

  int n_vec;
  int n_mis;
  int cyc;
  int steps[$];
  int s_cyc, d_cyc;
  int c_incr, c_done, c_opa, c_opb, c_exec, c_agu;
  int c_req, c_rs2, c_busy, c_rs1req, c_rs1inc;

  function automatic logic [11:0] outs();
    return {busy_o, done_o, exec_o, opa_we_o, opb_we_o,
            mem_req_o, mem_we_o, get_rs1_o, get_rs2_o,
            get_rd_o, incr_o, agu_load_o};
  endfunction

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(int vl, bit two);
    if (vl == 0) begin
      steps.push_back(K_DONE);
      return;
    end
    steps.push_back(K_LOAD);
    steps.push_back(K_AWAIT);
    for (int e = 0; e < vl; e++) begin
      steps.push_back(K_REQA);
      steps.push_back(K_RSPA);
      if (two) begin
        steps.push_back(K_REQB);
        steps.push_back(K_RSPB);
      end
      steps.push_back(K_EXEC);
      steps.push_back(K_XWAIT);
      steps.push_back(K_WREQ);
      steps.push_back(K_WRSP);
    end
    steps.push_back(K_DONE);
  endtask

  task automatic model_step();
    logic [11:0] exp;
    logic [11:0] act;
    bit          adv;
    exp = '0;
    adv = 0;
    act = outs();
    if (!rst_ni) begin
      steps.delete();
    end else if (steps.size() == 0) begin
      if (start_i) begin
        s_cyc = cyc;
        build(int'(vl_i), two_src_i);
      end
    end else begin
      exp[B_BUSY] = 1'b1;
      case (steps[0])
        K_LOAD:  begin exp[B_AGU] = 1'b1; adv = 1; end
        K_AWAIT: adv = agu_ready_i;
        K_REQA, K_REQB, K_WREQ: begin
          exp[B_REQ] = 1'b1;
          exp[B_INC] = mem_gnt_i;
          exp[B_RS1] = (steps[0] == K_REQA);
          exp[B_RS2] = (steps[0] == K_REQB);
          exp[B_RD]  = (steps[0] == K_WREQ);
          exp[B_WE]  = (steps[0] == K_WREQ);
          adv = mem_gnt_i;
        end
        K_RSPA:  begin exp[B_OPA] = mem_rvalid_i; adv = mem_rvalid_i; end
        K_RSPB:  begin exp[B_OPB] = mem_rvalid_i; adv = mem_rvalid_i; end
        K_EXEC:  begin exp[B_EXE] = 1'b1; adv = 1; end
        K_XWAIT: adv = res_valid_i;
        K_WRSP:  adv = mem_rvalid_i;
        default: begin exp[B_DONE] = 1'b1; adv = 1; end
      endcase
      if (adv) void'(steps.pop_front());
    end
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL cycle %0d outputs: got %b expected %b", cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_step();
    if (done_o) d_cyc = cyc;
    c_incr   += int'(incr_o);
    c_done   += int'(done_o);
    c_opa    += int'(opa_we_o);
    c_opb    += int'(opb_we_o);
    c_exec   += int'(exec_o);
    c_agu    += int'(agu_load_o);
    c_req    += int'(mem_req_o);
    c_rs2    += int'(get_rs2_o);
    c_busy   += int'(busy_o);
    c_rs1req += int'(mem_req_o && get_rs1_o);
    c_rs1inc += int'(incr_o && get_rs1_o);
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    c_incr = 0; c_done = 0; c_opa = 0; c_opb = 0;
    c_exec = 0; c_agu = 0; c_req = 0; c_rs2 = 0;
    c_busy = 0; c_rs1req = 0; c_rs1inc = 0;
  endtask

  task automatic run(int vl, bit two, int budget);
    clr();
    vl_i      = 8'(vl);
    two_src_i = two;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int i = 0; i < budget && busy_o; i++) tick();
    if (busy_o) check("op_timeout", 1, 0);
  endtask

  initial begin
    n_vec = 0; n_mis = 0; cyc = 0;
    s_cyc = -1; d_cyc = -1;
    rst_ni = 1'b0; start_drv = 1'b0;
    vl_i = '0; two_src_i = 1'b0;
    gnt_delay_cfg = 0; res_delay = 0; inject = 0;
    clr();
    @(posedge clk_i);
    #1;
    tick();
    check("reset_outs", int'(outs()), 0);
    rst_ni = 1'b1;

    run(1, 1'b1, 100);
    check("t1_incr", c_incr, 3);
    check("t1_done", c_done, 1);
    check("t1_opb", c_opb, 1);

    run(3, 1'b0, 200);
    check("t2_rs2", c_rs2, 0);
    check("t2_opa", c_opa, 3);
    check("t2_exec", c_exec, 3);
    check("t2_incr", c_incr, 6);
    check("t2_done", c_done, 1);

    tick();
    run(0, 1'b1, 20);
    check("t3_agu", c_agu, 0);
    check("t3_req", c_req, 0);
    check("t3_busy", c_busy, 1);
    check("t3_done_lat", d_cyc - s_cyc, 1);

    gnt_delay_cfg = 4;
    tick();
    run(1, 1'b0, 100);
    check("t4_rs1_hold", c_rs1req, 5);
    check("t4_rs1_incr", c_rs1inc, 1);
    check("t4_incr", c_incr, 2);
    gnt_delay_cfg = 0;

    res_delay = 3;
    inject = 1;
    tick();
    run(1, 1'b1, 100);
    check("t5_opa", c_opa, 1);
    check("t5_opb", c_opb, 1);
    check("t5_exec", c_exec, 1);
    check("t5_done", c_done, 1);
    res_delay = 0;
    inject = 0;

    tick();
    run(255, 1'b0, 5000);
    check("t6_exec", c_exec, 255);
    check("t6_done", c_done, 1);

    gnt_delay_cfg = 50;
    tick();
    vl_i = 8'd5;
    two_src_i = 1'b0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int i = 0; i < 300 && !get_rd_o; i++) tick();
    check("t7_reach_wr", int'(get_rd_o), 1);
    rst_ni = 1'b0;
    #1;
    check("t7_rst_outs", int'(outs()), 0);
    tick();
    tick();
    gnt_delay_cfg = 0;
    rst_ni = 1'b1;
    run(2, 1'b0, 100);
    check("t7_exec", c_exec, 2);
    check("t7_done", c_done, 1);
    check("t7_incr", c_incr, 4);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/vce2_vec_seq.md
VCE2_VEC_SEQ -- requirements
Module: vce2_vec_seq

Interface
REQ-001 SHALL have parameter VlWidth, default 8, the width of the vector-length and element counters.
REQ-002 SHALL have clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start_i  input  1  start a vector operation; sampled only in IDLE.
REQ-005 SHALL have vl_i  input  VlWidth  number of 32-bit elements, captured with start_i.
REQ-006 SHALL have two_src_i  input  1  1 = operation reads rs2, 0 = rs1 only; captured with start_i.
REQ-007 SHALL have agu_load_o  output  1  one-cycle pulse that starts the AGU address load.
REQ-008 SHALL have agu_ready_i  input  1  AGU address load complete.
REQ-009 SHALL have get_rs1_o, get_rs2_o, get_rd_o  output  1 each  AGU address select; one-hot or all zero.
REQ-010 SHALL have incr_o  output  1  AGU post-increment of the selected address.
REQ-011 SHALL have mem_req_o  output  1  memory request, plus mem_we_o  output  1  write enable.
REQ-012 SHALL have mem_gnt_i  input  1  request accepted, plus mem_rvalid_i  input  1  response valid.
REQ-013 SHALL have opa_we_o, opb_we_o  output  1 each  capture of read data into operand A or operand B.
REQ-014 SHALL have exec_o  output  1  one-cycle pulse that starts the execute unit, plus res_valid_i  input  1  result ready.
REQ-015 SHALL have busy_o  output  1  high whenever the state is not IDLE, plus done_o  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, AGU_LD, AGU_WAIT, RA_REQ, RA_WAIT, RB_REQ, RB_WAIT, EXEC_ST, EXEC_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-017 SHALL transition IDLE->AGU_LD on start_i when vl_i!=0, and IDLE->DONE on start_i when vl_i==0; in the vl_i==0 case the AGU and memory are not touched.
REQ-018 SHALL, when leaving IDLE on start_i, load cnt_q=vl_i and src2_q=two_src_i.
REQ-019 SHALL assert agu_load_o in AGU_LD only, then go to AGU_WAIT.
REQ-020 SHALL stay in AGU_WAIT until agu_ready_i, then go to RA_REQ.
REQ-021 SHALL behave as follows in RA_REQ: mem_req_o=1, mem_we_o=0, get_rs1_o=1; incr_o=mem_gnt_i; on mem_gnt_i go to RA_WAIT.
REQ-022 SHALL behave as follows in RA_WAIT: opa_we_o=mem_rvalid_i; on mem_rvalid_i go to RB_REQ if src2_q, else to EXEC_ST.
REQ-023 SHALL handle RB_REQ/RB_WAIT the same as RA_REQ/RA_WAIT, but with get_rs2_o and opb_we_o; RB_WAIT goes to EXEC_ST.
REQ-024 SHALL assert exec_o for the single cycle in EXEC_ST, then go to EXEC_WAIT; it SHALL stay in EXEC_WAIT until res_valid_i, then go to WR_REQ.
REQ-025 SHALL behave as follows in WR_REQ: mem_req_o=1, mem_we_o=1, get_rd_o=1; incr_o=mem_gnt_i; on mem_gnt_i go to WR_WAIT.
REQ-026 SHALL, in WR_WAIT, on mem_rvalid_i decrement cnt_q, then go to DONE if cnt_q was 1, else to RA_REQ.
REQ-027 SHALL assert done_o for the single cycle in DONE, then return to IDLE.
REQ-028 SHALL keep mem_req_o high and the get_* select stable until mem_gnt_i (no request withdrawal).
REQ-029 SHALL assert incr_o only in a cycle where mem_req_o && mem_gnt_i.
REQ-030 SHALL ignore mem_rvalid_i and res_valid_i outside their WAIT states.
REQ-031 SHALL ignore start_i while busy_o=1.
REQ-032 SHALL treat vl_i as unsigned; vl_i = 2^VlWidth-1 performs that many elements without wrap.
REQ-033 SHALL default all outputs other than busy_o to 0 in every state not listed as driving them.

Reset
REQ-034 SHALL, while rst_ni=0, force state=IDLE, cnt_q=0, src2_q=0 and all outputs to 0, including mid-operation; no request is held across reset.
REQ-035 SHALL accept start_i in the first cycle after reset deasserts.

Verification
REQ-036 SHALL test: start, vl=1, two_src=1, gnt and rvalid same-cycle responses -> sequence rs1 read, rs2 read, exec, rd write; exactly 3 incr_o pulses; done_o once.
REQ-037 SHALL test: start, vl=3, two_src=0 -> get_rs2_o never high; 3 opa_we_o pulses, 3 exec_o pulses, 6 incr_o pulses; done_o after the third write response.
REQ-038 SHALL test: start, vl=0 -> agu_load_o=0 and mem_req_o=0 throughout; done_o in the cycle after start; busy_o high for 1 cycle.
REQ-039 SHALL test: gnt delayed 4 cycles in RA_REQ -> mem_req_o and get_rs1_o held for 5 cycles; incr_o high only in the gnt cycle.
REQ-040 SHALL test: start_i pulsed during EXEC_WAIT, and rvalid injected during EXEC_WAIT -> no state change, and no opa_we_o or opb_we_o.
REQ-041 SHALL test: rst_ni low during WR_REQ with vl=5 -> all outputs 0 immediately, state IDLE; a new start with vl=2 then completes normally.
